// File: rtl/serial_tx_piso.sv
// -----------------------------------------------------------------------------
// serial_tx_piso
// Parallel-in / serial-out frame transmitter for a single-wire serial link.
// A DATA_W-bit word is taken over a valid/ready handshake and sent out
// LSB first. The frame is one start bit (0), the payload bits, then one stop
// bit (1). Each serial bit is held for CLKS_PER_BIT clocks. The line idles
// high.
//
// Ports
//   clk        rising-edge clock, single clock domain
//   reset      synchronous active-high reset; takes priority over everything
//   tx_data    word to send; sampled only on an accept edge
//   tx_valid   producer has a word on tx_data
//   tx_ready   block can accept a word (accept = tx_valid & tx_ready at an edge)
//   tx_serial  registered serial line, idle level 1
//   tx_busy    high while a frame is in progress
//   tx_done    one-clock pulse in the cycle after the frame's final edge
//
// All outputs are registered. The frame lasts (DATA_W+2)*CLKS_PER_BIT clocks,
// counted from the accept edge to the edge that raises tx_ready again.
// -----------------------------------------------------------------------------
module serial_tx_piso #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  // The divider needs at least one bit, even when CLKS_PER_BIT is 1 and it
  // never leaves zero.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              div_last;

  // Shifted copy of the payload. Taking the next bit from here rather than
  // from shreg[1] keeps DATA_W = 1 legal.
  assign shreg_next = shreg >> 1;

  // High on the last clock of the current bit period; that edge advances the
  // state or the bit index.
  assign div_last = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shreg is deliberately left out of reset. It is pure payload,
      // always reloaded on accept, and never observed while IDLE.
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      // tx_done is a single-cycle strobe. Only the final STOP edge sets it.
      tx_done <= 1'b0;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (tx_valid && tx_ready) begin
            shreg     <= tx_data;
            state     <= START;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end

        START: begin
          if (div_last) begin
            div_cnt   <= '0;
            state     <= DATA;
            tx_serial <= shreg[0];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DATA: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              shreg     <= shreg_next;
              tx_serial <= shreg_next[0];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          if (div_last) begin
            div_cnt  <= '0;
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_piso.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_piso
// Self-checking bench for serial_tx_piso. It instantiates three copies:
//   u_a : DATA_W=8, CLKS_PER_BIT=4
//   u_b : DATA_W=8, CLKS_PER_BIT=1
//   u_c : DATA_W=4, CLKS_PER_BIT=2
// 'sel' picks which copy receives tx_valid and which copy is observed.
// The expected line level for each clock of a frame comes from the frame
// definition: bit period index = cycle / CLKS_PER_BIT, where period 0 is the
// start bit, periods 1..DATA_W are the payload (LSB first), and the last
// period is the stop bit.
// -----------------------------------------------------------------------------
module tb_serial_tx_piso;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         sel;

  logic a_ready, a_serial, a_busy, a_done;
  logic b_ready, b_serial, b_busy, b_done;
  logic c_ready, c_serial, c_busy, c_done;

  logic o_ready, o_serial, o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // During reset every copy sees tx_valid, so the bench can show that all of
  // them ignore it.
  logic a_valid, b_valid, c_valid;
  assign a_valid = tx_valid && (sel == 0 || reset);
  assign b_valid = tx_valid && (sel == 1 || reset);
  assign c_valid = tx_valid && (sel == 2 || reset);

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_serial(a_serial), .tx_busy(a_busy), .tx_done(a_done)
  );

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_serial(b_serial), .tx_busy(b_busy), .tx_done(b_done)
  );

  serial_tx_piso #(.DATA_W(4), .CLKS_PER_BIT(2)) u_c (
    .clk(clk), .reset(reset), .tx_data(tx_data[3:0]), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_serial(c_serial), .tx_busy(c_busy), .tx_done(c_done)
  );

  always_comb begin
    o_ready  = a_ready;
    o_serial = a_serial;
    o_busy   = a_busy;
    o_done   = a_done;
    case (sel)
      1: begin
        o_ready = b_ready; o_serial = b_serial; o_busy = b_busy; o_done = b_done;
      end
      2: begin
        o_ready = c_ready; o_serial = c_serial; o_busy = c_busy; o_done = c_done;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected line level k clocks after the accept edge (k = 0 is the first
  // clock of the start bit).
  function automatic logic exp_line(input logic [7:0] d, input int w,
                                    input int c, input int k);
    int period;
    period = k / c;
    if (period == 0)  return 1'b0;
    if (period <= w)  return d[period-1];
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag, input logic done_exp);
    check($sformatf("%s serial", tag), o_serial, 1'b1);
    check($sformatf("%s ready",  tag), o_ready,  1'b1);
    check($sformatf("%s busy",   tag), o_busy,   1'b0);
    check($sformatf("%s done",   tag), o_done,   done_exp);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_idle($sformatf("%s idle%0d", tag, i), 1'b0);
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the selected copy ready. Offers d, then checks
  // every clock of the frame and the tx_done cycle. hold keeps tx_valid high
  // after the accept; chg_at (>=0) swaps tx_data mid-frame; abort_at (>=0)
  // pulses reset during that clock and ends the task after checking recovery.
  task automatic send_frame(input logic [7:0] d, input int w, input int c,
                            input bit hold, input int chg_at,
                            input logic [7:0] chg_d, input int abort_at,
                            input string tag);
    int len;
    len = (w + 2) * c;
    check($sformatf("%s ready_pre", tag), o_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == chg_at) tx_data = chg_d;
      check($sformatf("%s serial k=%0d", tag, k), o_serial, exp_line(d, w, c, k));
      check($sformatf("%s ready k=%0d",  tag, k), o_ready,  1'b0);
      check($sformatf("%s busy k=%0d",   tag, k), o_busy,   1'b1);
      check($sformatf("%s done k=%0d",   tag, k), o_done,   1'b0);
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle($sformatf("%s abort", tag), 1'b0);
        @(negedge clk);
        check_idle($sformatf("%s abort+1", tag), 1'b0);
        return;
      end
      @(negedge clk);
    end
    check_idle($sformatf("%s end", tag), 1'b1);
  endtask

  initial begin
    int   w, c;
    bit   hold;
    logic [7:0] d;

    sel      = 0;
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;

    // Reset held two clocks with valid asserted: nothing may start.
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle($sformatf("reset u%0d", s), 1'b0);
    end
    sel = 0;
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle($sformatf("post_reset u%0d", s), 1'b0);
    end
    sel = 0;
    @(negedge clk);

    // Single frame 8'hA5, 4 clocks per bit.
    send_frame(8'hA5, 8, 4, 1'b0, -1, 8'h00, -1, "a5");
    @(negedge clk);
    idle_cycles(2, "a5");

    // Back-to-back with tx_valid held; data changes mid-frame. The second
    // word is accepted on the tx_done edge, so the line is high for the
    // stop bit plus one clock.
    send_frame(8'h3C, 8, 4, 1'b1, 10, 8'hC3, -1, "b2b_1");
    send_frame(8'hC3, 8, 4, 1'b1, -1, 8'h00, -1, "b2b_2");
    tx_valid = 1'b0;
    @(negedge clk);
    idle_cycles(2, "b2b");

    // Reset during data bit 3 of 8'h0F, then a clean frame 8'h81.
    send_frame(8'h0F, 8, 4, 1'b0, -1, 8'h00, 17, "abort");
    send_frame(8'h81, 8, 4, 1'b0, -1, 8'h00, -1, "after_abort");
    @(negedge clk);
    idle_cycles(1, "after_abort");

    // One clock per bit.
    sel = 1;
    #1;
    send_frame(8'h01, 8, 1, 1'b0, -1, 8'h00, -1, "cpb1");
    @(negedge clk);
    idle_cycles(1, "cpb1");

    // Four-bit payload, two clocks per bit.
    sel = 2;
    #1;
    send_frame(8'h09, 4, 2, 1'b0, -1, 8'h00, -1, "w4");
    @(negedge clk);
    idle_cycles(1, "w4");

    // Randomized frames on every copy, with random gaps, held valid and
    // mid-frame data changes.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      w = (s == 2) ? 4 : 8;
      c = (s == 0) ? 4 : ((s == 1) ? 1 : 2);
      for (int r = 0; r < 6; r++) begin
        d    = 8'($urandom);
        hold = 1'($urandom);
        send_frame(d, w, c, hold, int'($urandom_range(0, 9)), 8'($urandom), -1,
                   $sformatf("rnd u%0d #%0d", s, r));
        if (!hold || r == 5) begin
          tx_valid = 1'b0;
          @(negedge clk);
          idle_cycles(int'($urandom_range(0, 3)), $sformatf("rnd u%0d #%0d", s, r));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
- Parallel-in / serial-out frame transmitter: the transmit end of the single-wire serial link whose receive side is a chain of edge-triggered D flip-flops sampling one bit per bit period.
- Accepts a DATA_W-bit word via a valid/ready handshake and shifts it out LSB first. Each word is framed by one start bit (0) and one stop bit (1), and each bit is held for CLKS_PER_BIT clocks.
- Sits between a word-producing register stage and the serial line; the line idles high.

Parameters:
- DATA_W, 8, payload bits per frame (>=1).
- CLKS_PER_BIT, 4, clocks each serial bit is held (>=1).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  word to send; sampled only on an accept edge.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word; accept = tx_valid & tx_ready at a rising clk edge.
- tx_serial  output  1  serial line, registered; idle level 1.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-clock pulse when a frame completes.

Behaviour:
- All outputs are registered. Reset has priority over everything else.
- Reset (sampled at an edge):
  - Next state IDLE.
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Bit counter and divider counter cleared.
  - Any frame in flight is aborted with no tx_done pulse.
  - tx_valid is ignored while reset=1.
- FSM states: IDLE, START, DATA, STOP.
- Divider counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A state/bit advances on the edge where the counter equals CLKS_PER_BIT-1; the counter then returns to 0.
- IDLE:
  - tx_serial=1, tx_ready=1, tx_busy=0.
  - On an accept edge: latch tx_data into the shift register, go to START, drive tx_serial<=0, tx_ready<=0, tx_busy<=1.
- START: line held 0 for CLKS_PER_BIT clocks, then go to DATA with tx_serial<=shreg[0].
- DATA:
  - Each bit is held CLKS_PER_BIT clocks; then shift right and drive the next bit.
  - After bit DATA_W-1 completes, go to STOP with tx_serial<=1.
  - A DATA_W-sized bit counter (width clog2(DATA_W)+1) tracks the bit index.
- STOP:
  - Line held 1 for CLKS_PER_BIT clocks.
  - On the final edge: go to IDLE with tx_ready<=1, tx_busy<=0, tx_done<=1 for exactly one clock.
- Frame length: (DATA_W+2)*CLKS_PER_BIT clocks, measured from the accept edge to the edge that raises tx_ready.
- Back-to-back frames:
  - A word can be accepted on the first edge after tx_ready rises, which is the same cycle tx_done is high.
  - The line is therefore high for at least CLKS_PER_BIT+1 clocks between frames.
- tx_data and tx_valid changes while busy have no effect on the frame in flight. tx_valid may stay high continuously; there is no implicit extra accept.
- CLKS_PER_BIT=1 is legal: one clock per bit, no divider wait.
- Latency: the start bit appears on tx_serial in the cycle immediately after the accept edge.

Test Plan:
- Reset: hold reset for 2 clocks with tx_valid=1, tx_data=8'hFF -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0; no frame starts.
- Single frame, 8'hA5, CLKS_PER_BIT=4:
  - tx_serial is 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then 1 for 4 clocks.
  - tx_ready is low for exactly 40 clocks.
  - tx_done pulses once, in the cycle tx_ready returns high.
- Back-to-back with held valid: tx_valid high throughout; tx_data=8'h3C accepted; tx_data changed to 8'hC3 mid-frame ->
  - First frame serializes 8'h3C unchanged.
  - 8'hC3 is accepted on the edge where tx_done=1.
  - Line stays high for 5 clocks between the two frames.
- Reset mid-frame: assert reset for 1 clock during data bit 3 of 8'h0F -> next cycle tx_serial=1, tx_ready=1, tx_busy=0, no tx_done; a following frame of 8'h81 is transmitted correctly.
- CLKS_PER_BIT=1 instance, send 8'h01 -> 10-clock frame 0,1,0,0,0,0,0,0,0,1; tx_done is 1 in cycle 11 after the accept edge.
- DATA_W=4, CLKS_PER_BIT=2 instance, send 4'h9 -> frame 0,1,0,0,1,1 at 2 clocks per bit; frame length 12 clocks.
